// File: rtl/approx_add_sequencer.sv
// Approximate adder that runs one nibble per clock through a single 4-bit carry-maskable slice.
// Optional macro APPROX_ERR_MON_EN adds err_dist/err_flag outputs that compare each result with the exact sum.
module approx_add_sequencer #(
    parameter  int WIDTH = 16,
    localparam int LVL_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [LVL_W-1:0] lvl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef APPROX_ERR_MON_EN
    ,
    output logic [WIDTH:0]   err_dist,
    output logic             err_flag
`endif
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   mask_q, mask_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;

    logic [WIDTH-1:0]   mask_new;
    logic [CNT_W+1:0]   base;
    logic [3:0]         nib_a, nib_b, nib_m, nib_s;
    logic [4:0]         c_chain;
    logic               last_nib;

`ifdef APPROX_ERR_MON_EN
    logic [WIDTH:0]     err_dist_q, err_dist_d;
    logic               err_flag_q, err_flag_d;
    logic [WIDTH:0]     exact;
`endif

    // Bit i is approximate when i < lvl; any lvl >= WIDTH masks every bit, which is the clamp.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            mask_new[i] = (lvl > LVL_W'(i));
        end
    end

    // Single 4-bit slice: masked bits neither generate nor propagate a carry.
    always_comb begin
        base       = {cnt_q, 2'b00};
        nib_a      = a_q[base +: 4];
        nib_b      = b_q[base +: 4];
        nib_m      = mask_q[base +: 4];
        c_chain[0] = carry_q;
        for (int i = 0; i < 4; i++) begin
            nib_s[i]     = nib_a[i] ^ nib_b[i] ^ c_chain[i];
            c_chain[i+1] = nib_m[i] ? 1'b0
                                    : (nib_a[i] & nib_b[i]) | ((nib_a[i] ^ nib_b[i]) & c_chain[i]);
        end
        last_nib = (cnt_q == CNT_W'(NIB - 1));
    end

    // NOTE: every signal written below gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef APPROX_ERR_MON_EN
        err_dist_d = err_dist_q;
        err_flag_d = err_flag_q;
        exact      = {1'b0, a_q} + {1'b0, b_q};
`endif
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    mask_d  = mask_new;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[base +: 4] = nib_s;
                carry_d          = c_chain[4];
                cnt_d            = cnt_q + 1'b1;
                if (last_nib) begin
                    cout_d  = c_chain[4];
                    state_d = S_DONE;
`ifdef APPROX_ERR_MON_EN
                    err_dist_d = exact - {c_chain[4], sum_d};
                    err_flag_d = (err_dist_d != '0);
`endif
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef APPROX_ERR_MON_EN
            err_dist_q <= '0;
            err_flag_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef APPROX_ERR_MON_EN
            err_dist_q <= err_dist_d;
            err_flag_q <= err_flag_d;
`endif
        end
    end

    // NOTE: operand and mask registers are left unreset; they are always loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        a_q    <= a_d;
        b_q    <= b_d;
        mask_q <= mask_d;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef APPROX_ERR_MON_EN
    assign err_dist  = err_dist_q;
    assign err_flag  = err_flag_q;
`endif

endmodule

// File: tb/tb_approx_add_sequencer.sv
// Self-checking bench for approx_add_sequencer (WIDTH=16), using randomized and directed operations.
// The reference model treats the masked low bits as carry-free XOR and adds the upper bits exactly.
module tb_approx_add_sequencer;

    localparam int WIDTH = 16;
    localparam int LVL_W = $clog2(WIDTH + 1);
    localparam int LAT   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [LVL_W-1:0] lvl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef APPROX_ERR_MON_EN
    logic [WIDTH:0]   err_dist;
    logic             err_flag;
`endif

    int checks   = 0;
    int failures = 0;

    approx_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .lvl       (lvl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef APPROX_ERR_MON_EN
        ,
        .err_dist  (err_dist),
        .err_flag  (err_flag)
`endif
    );

    always #5 clk = ~clk;

    // With a contiguous low mask no carry ever reaches bit l, so the upper part is an exact add of the upper bits.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic [LVL_W-1:0] lv);
        int unsigned l, m, hi, r;
        l  = (int'(lv) > WIDTH) ? WIDTH : int'(lv);
        m  = (32'd1 << l) - 32'd1;
        hi = (32'(x) >> l) + (32'(y) >> l);
        r  = (hi << l) | ((32'(x) ^ 32'(y)) & m);
        return r[WIDTH:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents an operand pair and returns just after the accepting edge.
    task automatic send(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic [LVL_W-1:0] lv);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        lvl      = lv;
        for (int k = 0; k < 20 && !in_ready; k++) tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s accept: in_ready got %b want 1 within 20 clks", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    // Waits for out_valid and returns the number of clocks since the accepting edge.
    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic [LVL_W-1:0] lv, input int lat);
        logic [WIDTH:0] exp_r;
        exp_r = model(x, y, lv);
        checks++;
        if (lat != LAT || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s latency: got %0d clks (out_valid=%b) want %0d", name, lat, out_valid, LAT);
        end
        checks++;
        if ({cout, sum} !== exp_r) begin
            failures++;
            $display("FAIL %s result: a=%h b=%h lvl=%0d got cout=%b sum=%h want cout=%b sum=%h",
                     name, x, y, lv, cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
        end
`ifdef APPROX_ERR_MON_EN
        begin
            logic [WIDTH:0] exp_e;
            exp_e = ({1'b0, x} + {1'b0, y}) - exp_r;
            checks++;
            if (err_dist !== exp_e || err_flag !== (exp_e != 0)) begin
                failures++;
                $display("FAIL %s err_mon: got dist=%0d flag=%b want dist=%0d flag=%b",
                         name, err_dist, err_flag, exp_e, (exp_e != 0));
            end
        end
`endif
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s release: got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     name, in_ready, out_valid, busy);
        end
    endtask

    task automatic do_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input logic [LVL_W-1:0] lv);
        int lat;
        send(name, x, y, lv);
        wait_done(lat);
        check_result(name, x, y, lv, lat);
        release_result(name);
    endtask

    task automatic check_idle_zero(input string name);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
            failures++;
            $display("FAIL %s idle state: got in_ready=%b out_valid=%b busy=%b sum=%h cout=%b want 1 0 0 0000 0",
                     name, in_ready, out_valid, busy, sum, cout);
        end
`ifdef APPROX_ERR_MON_EN
        checks++;
        if (err_dist !== '0 || err_flag !== 1'b0) begin
            failures++;
            $display("FAIL %s err reset: got dist=%0d flag=%b want 0 0", name, err_dist, err_flag);
        end
`endif
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        lvl       = '0;
        tick();
        tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();
        check_idle_zero("post_reset");
    endtask

    task automatic test_directed();
        do_op("exact_add",  16'h00FF, 16'h0001, 5'd0);
        do_op("approx_add", 16'h00FF, 16'h0001, 5'd4);
        do_op("wrap",       16'hFFFF, 16'h0001, 5'd0);
        do_op("clamp17",    16'hFFFF, 16'h0001, 5'd17);
        do_op("clamp31",    16'hA5C3, 16'h3C5A, 5'd31);
        do_op("lvl16",      16'h8001, 16'h8001, 5'd16);
        do_op("lvl15",      16'hC000, 16'h4000, 5'd15);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 5'($urandom_range(0, 20)));
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [WIDTH:0] exp_r;
        exp_r = model(16'h1234, 16'hEDCC, 5'd3);
        send("bp", 16'h1234, 16'hEDCC, 5'd3);
        wait_done(lat);
        check_result("bp", 16'h1234, 16'hEDCC, 5'd3, lat);
        in_valid = 1'b1;
        a        = 16'h0F0F;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || {cout, sum} !== exp_r) begin
                failures++;
                $display("FAIL bp hold%0d: got out_valid=%b in_ready=%b busy=%b cout=%b sum=%h want 1 0 1 %b %h",
                         i, out_valid, in_ready, busy, cout, sum, exp_r[WIDTH], exp_r[WIDTH-1:0]);
            end
        end
        in_valid = 1'b0;
        release_result("bp");
        do_op("bp_next", 16'h7FFF, 16'h0001, 5'd0);
    endtask

    task automatic test_reset_mid_run();
        send("midrst", 16'hFFFF, 16'hFFFF, 5'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_idle_zero("midrst");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL midrst partial%0d: out_valid got %b want 0", i, out_valid);
            end
            tick();
        end
        do_op("midrst_next", 16'h0FF0, 16'h0010, 5'd2);
    endtask

    task automatic test_ignored_input();
        int lat;
        send("ignore", 16'h00FF, 16'h0001, 5'd0);
        in_valid = 1'b1;
        a        = 16'hFF00;
        b        = 16'h0F0F;
        lvl      = 5'd8;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL ignore in_ready: got %b want 0 during RUN", in_ready);
        end
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        lat = lat + 1;
        check_result("ignore", 16'h00FF, 16'h0001, 5'd0, lat);
        release_result("ignore");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_ignored_input();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
